// File: rtl/alu_reg_file.sv
// Operand register file feeding the ALU: two combinational read ports, one write port,
// registered ZF/OF flags and a clear sweep. Optional macro RF_BYPASS_EN adds write-to-read forwarding.
module alu_reg_file #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flag_we,
  input  logic              zf_in,
  input  logic              of_in,
  output logic              zf,
  output logic              of,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  assign busy = (state == S_CLEAR);

  // Control FSM: sweep pointer, flags and the refused-write pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_CLEAR;
      ptr     <= '0;
      zf      <= 1'b0;
      of      <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      wr_drop <= (state == S_CLEAR) && (we || flag_we);
      if (state == S_CLEAR) begin
        if (ptr == LAST_PTR) begin
          state <= S_READY;
          ptr   <= '0;
        end else begin
          ptr <= ptr + 1'b1;
        end
      end else if (clr) begin
        state <= S_CLEAR;
        ptr   <= '0;
        zf    <= 1'b0;
        of    <= 1'b0;
      end else if (flag_we) begin
        zf <= zf_in;
        of <= of_in;
      end
    end
  end

  // NOTE: the array has no reset; the sweep zeroes it, which keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[ptr[ADDR_W-1:0]] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (!busy) begin
      if (raddr_a != '0) rdata_a = mem[raddr_a];
      if (raddr_b != '0) rdata_b = mem[raddr_b];
`ifdef RF_BYPASS_EN
      if (we && (waddr != '0)) begin
        if (waddr == raddr_a) rdata_a = wdata;
        if (waddr == raddr_b) rdata_b = wdata;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_reg_file.sv
// Scoreboard bench for alu_reg_file: stimulus queues expected values, a negedge monitor compares them.
module tb_alu_reg_file;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic [ADDR_W-1:0] raddr_a, raddr_b, waddr;
  logic [DATA_W-1:0] rdata_a, rdata_b, wdata;
  logic              we, flag_we, zf_in, of_in;
  logic              zf, of, busy, wr_drop;

  alu_reg_file #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .flag_we (flag_we),
    .zf_in   (zf_in),
    .of_in   (of_in),
    .zf      (zf),
    .of      (of),
    .busy    (busy),
    .wr_drop (wr_drop)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {SIG_RA, SIG_RB, SIG_BUSY, SIG_ZF, SIG_OF, SIG_DROP} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic exp_push(input string name, input sig_e sig, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: drains every queued expectation at the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sig)
        SIG_RA:   act = rdata_a;
        SIG_RB:   act = rdata_b;
        SIG_BUSY: act = {31'b0, busy};
        SIG_ZF:   act = {31'b0, zf};
        SIG_OF:   act = {31'b0, of};
        default:  act = {31'b0, wr_drop};
      endcase
      check(e.name, act, e.exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; we = 1'b0; flag_we = 1'b0;
    zf_in = 1'b0; of_in = 1'b0; waddr = '0; wdata = '0;
    raddr_a = 5'd1; raddr_b = 5'd2;
    steps(2);
    exp_push("rst_busy", SIG_BUSY, 1);
    exp_push("rst_zf",   SIG_ZF,   0);
    exp_push("rst_of",   SIG_OF,   0);
    exp_push("rst_drop", SIG_DROP, 0);
    exp_push("rst_ra",   SIG_RA,   0);

    // Release reset with a write to r5 in the first CLEAR cycle: refused.
    step();
    rst_n = 1'b1;
    we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678; raddr_a = 5'd5;
    step();                                   // edge 1
    we = 1'b0;
    exp_push("clear_drop_pulse", SIG_DROP, 1);
    exp_push("clear_busy_e1",    SIG_BUSY, 1);
    step();                                   // edge 2
    exp_push("clear_drop_one_cycle", SIG_DROP, 0);
    steps(29);                                // edge 31
    exp_push("reset_busy_e31", SIG_BUSY, 1);
    step();                                   // edge 32
    exp_push("reset_busy_e32", SIG_BUSY, 0);
    exp_push("r5_refused",     SIG_RA,   0);
    exp_push("ready_zf",       SIG_ZF,   0);
    exp_push("ready_of",       SIG_OF,   0);

    // All addresses read zero after the sweep.
    for (int a = 0; a < DEPTH; a += 2) begin
      raddr_a = 5'(a); raddr_b = 5'(a + 1);
      exp_push($sformatf("zero_a_r%0d", a), SIG_RA, 0);
      exp_push($sformatf("zero_b_r%0d", a + 1), SIG_RB, 0);
      step();
    end

    // Writes in READY, reads on both ports.
    we = 1'b1; waddr = 5'd1; wdata = 32'h7FFF_FFFF;
    step();
    waddr = 5'd2; wdata = 32'h8000_0000;
    step();
    we = 1'b0; raddr_a = 5'd1; raddr_b = 5'd2;
    exp_push("r1_read", SIG_RA, 32'h7FFF_FFFF);
    exp_push("r2_read", SIG_RB, 32'h8000_0000);
    exp_push("ready_write_no_drop", SIG_DROP, 0);
    step();
    raddr_b = 5'd1;
    exp_push("same_addr_a", SIG_RA, 32'h7FFF_FFFF);
    exp_push("same_addr_b", SIG_RB, 32'h7FFF_FFFF);
    step();

    // r0 is hardwired to zero and a write to it is not a drop.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr_a = 5'd0;
    step();
    we = 1'b0;
    exp_push("r0_zero", SIG_RA, 0);
    exp_push("r0_no_drop", SIG_DROP, 0);
    step();

    // Same-cycle read of the address being written.
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0607; raddr_a = 5'd3;
`ifdef RF_BYPASS_EN
    exp_push("bypass_same_cycle", SIG_RA, 32'h0000_0607);
`else
    exp_push("no_bypass_same_cycle", SIG_RA, 0);
`endif
    step();
    we = 1'b0;
    exp_push("r3_after_edge", SIG_RA, 32'h0000_0607);

    // Flags, coinciding with a data write.
    flag_we = 1'b1; zf_in = 1'b0; of_in = 1'b1;
    step();
    exp_push("flag01_zf", SIG_ZF, 0);
    exp_push("flag01_of", SIG_OF, 1);
    zf_in = 1'b1; of_in = 1'b1; we = 1'b1; waddr = 5'd6; wdata = 32'hDEAD_BEEF;
    step();
    flag_we = 1'b0; we = 1'b0; raddr_a = 5'd6;
    exp_push("flag11_zf", SIG_ZF, 1);
    exp_push("flag11_of", SIG_OF, 1);
    exp_push("r6_with_flags", SIG_RA, 32'hDEAD_BEEF);
    step();

    // clr with a coincident write to r4; the sweep later wipes it.
    clr = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h0000_00AA;
    raddr_a = 5'd1; raddr_b = 5'd2;
    step();                                   // E0: enter CLEAR
    clr = 1'b0; we = 1'b0;
    exp_push("clr_zf",    SIG_ZF,   0);
    exp_push("clr_of",    SIG_OF,   0);
    exp_push("clr_busy",  SIG_BUSY, 1);
    exp_push("clr_drop0", SIG_DROP, 0);
    exp_push("clr_ra_forced", SIG_RA, 0);
    flag_we = 1'b1; zf_in = 1'b1; of_in = 1'b1;
    step();                                   // E1
    flag_we = 1'b0;
    exp_push("flag_refused_drop", SIG_DROP, 1);
    exp_push("flag_refused_zf",   SIG_ZF,   0);
    steps(30);                                // E31
    exp_push("clr_busy_e31", SIG_BUSY, 1);
    step();                                   // E32
    exp_push("clr_busy_e32", SIG_BUSY, 0);
    exp_push("r1_cleared",   SIG_RA,   0);
    exp_push("r2_cleared",   SIG_RB,   0);
    step();
    raddr_a = 5'd4; raddr_b = 5'd3;
    exp_push("r4_cleared", SIG_RA, 0);
    exp_push("r3_cleared", SIG_RB, 0);

    // Reset mid-sweep at ptr = 17 restarts a full sweep.
    clr = 1'b1;
    step();                                   // E0
    clr = 1'b0;
    steps(17);                                // ptr = 17
    rst_n = 1'b0;
    #2;
    exp_push("midreset_busy", SIG_BUSY, 1);
    step();
    rst_n = 1'b1;
    steps(31);
    exp_push("restart_busy_e31", SIG_BUSY, 1);
    step();
    exp_push("restart_busy_e32", SIG_BUSY, 0);
    step();

    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
